// File: rtl/p_dec_3x8_buf.sv
// rtl/p_dec_3x8_buf.sv - buffered 3-to-8 decoder with output register and code FIFO
// Codes queue behind a registered one-hot output that is held until the consumer acks it.
module p_dec_3x8_buf #(
   parameter int DEPTH = 4,
   parameter int LW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    Q,
   input  logic          v,
   output logic          rdy,
   output logic [7:0]    D,
   output logic          D_v,
   input  logic          ack,
   output logic [LW-1:0] lvl,
   output logic          ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {EMPTY, SHOW} state_t;

   state_t        state, state_nx;
   logic [7:0]    d_q, d_nx;
   logic [2:0]    mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [LW-1:0] lvl_q, lvl_nx;
   logic          ovf_q;
   logic          full, empty, accept, take, push, pop, drain;

   assign empty  = (wp == rp);
   assign full   = (wp[PW-1] != rp[PW-1]) && (wp[AW-1:0] == rp[AW-1:0]);
   // rdy depends on registered pointers only, so a same-cycle ack never frees room for Q
   assign accept = v && !full;
   assign take   = (state == EMPTY) || ack;
   assign drain  = (state == SHOW) && ack;

   always_comb begin
      state_nx = state;
      d_nx     = d_q;
      push     = 1'b0;
      pop      = 1'b0;
      if (take) begin
         if (!empty) begin
            state_nx = SHOW;
            d_nx     = 8'h01 << mem[rp[AW-1:0]];
            pop      = 1'b1;
            push     = accept;
         end else if (accept) begin
            state_nx = SHOW;
            d_nx     = 8'h01 << Q;
         end else begin
            state_nx = EMPTY;
            d_nx     = 8'h00;
         end
      end else begin
         push = accept;
      end
   end

   always_comb begin
      lvl_nx = lvl_q;
      case ({accept, drain})
         2'b10:   lvl_nx = lvl_q + LW'(1);
         2'b01:   lvl_nx = lvl_q - LW'(1);
         default: lvl_nx = lvl_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
         d_q   <= 8'h00;
         wp    <= '0;
         rp    <= '0;
         lvl_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nx;
         d_q   <= d_nx;
         lvl_q <= lvl_nx;
         ovf_q <= ovf_q | (v && full);
         if (push) wp <= wp + PW'(1);
         if (pop)  rp <= rp + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp[AW-1:0]] <= Q;
   end

   assign rdy = !full;
   assign D   = d_q;
   assign D_v = (state == SHOW);
   assign lvl = lvl_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_p_dec_3x8_buf.sv
// tb/tb_p_dec_3x8_buf.sv - self-checking bench for p_dec_3x8_buf against a queue model
module tb_p_dec_3x8_buf;
   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          v = 1'b0;
   logic          ack = 1'b0;
   logic [2:0]    Q = 3'd0;
   logic          rdy, D_v, ovf;
   logic [7:0]    D;
   logic [LW-1:0] lvl;

   int         checks = 0;
   int         failures = 0;
   logic [2:0] mq[$];
   logic       movf = 1'b0;
   logic [7:0] drain_seq [5];

   always #5 clk = ~clk;

   p_dec_3x8_buf #(.DEPTH(DEPTH), .LW(LW)) dut (
      .clk(clk), .rst_n(rst_n), .Q(Q), .v(v), .rdy(rdy),
      .D(D), .D_v(D_v), .ack(ack), .lvl(lvl), .ovf(ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [7:0] ed;
      ed = (mq.size() > 0) ? (8'h01 << mq[0]) : 8'h00;
      chk("D", D, ed);
      chk("D_v", D_v, mq.size() > 0);
      chk("rdy", rdy, mq.size() < DEPTH + 1);
      chk("lvl", lvl, mq.size());
      chk("ovf", ovf, movf);
   endtask

   task automatic step(input logic r, input logic vv, input logic [2:0] qq, input logic aa);
      logic room;
      rst_n = r; v = vv; Q = qq; ack = aa;
      @(posedge clk);
      room = (mq.size() < DEPTH + 1);
      if (!r) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         if (aa && mq.size() > 0) void'(mq.pop_front());
         if (vv && room) mq.push_back(qq);
         if (vv && !room) movf = 1'b1;
      end
      @(negedge clk);
      check_model();
   endtask

   initial begin
      drain_seq[0] = 8'h02; drain_seq[1] = 8'h04; drain_seq[2] = 8'h08;
      drain_seq[3] = 8'h10; drain_seq[4] = 8'h00;

      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("idle_rdy", rdy, 1);

      // reset while holding codes
      step(1, 1, 1, 0); step(1, 1, 2, 0); step(1, 1, 3, 0);
      chk("pre_rst_lvl", lvl, 3);
      chk("pre_rst_Dv", D_v, 1);
      step(0, 1, 4, 0);
      chk("rst_D", D, 8'h00);
      chk("rst_lvl", lvl, 0);

      // single code
      step(1, 1, 5, 0);
      chk("single_D", D, 8'h20);
      step(1, 0, 0, 0);
      chk("single_hold", D, 8'h20);
      step(1, 0, 0, 1);
      chk("single_ack_Dv", D_v, 0);

      // burst into full, overflow, then drain
      for (int i = 0; i < 8; i++) step(1, 1, 3'(i), 0);
      chk("burst_lvl", lvl, 5);
      chk("burst_ovf", ovf, 1);
      chk("burst_head", D, 8'h01);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 1);
         chk("drain_D", D, drain_seq[i]);
      end

      // streaming with continuous ack
      step(0, 0, 0, 0);
      step(1, 1, 3, 1); chk("stream0", D, 8'h08);
      step(1, 1, 6, 1); chk("stream1", D, 8'h40);
      step(1, 1, 1, 1); chk("stream2", D, 8'h02);
      chk("stream_ovf", ovf, 0);

      // full plus simultaneous ack and v
      step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 3'(7 - i), 0);
      step(1, 1, 2, 1);
      chk("full_ack_lvl", lvl, 4);
      chk("full_ack_ovf", ovf, 1);
      chk("full_ack_rdy", rdy, 1);

      // pointer wrap with occupancy held steady
      step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 3'($urandom), 0);
      for (int i = 0; i < 3 * DEPTH; i++) step(1, 1, 3'($urandom), 1);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) != 0),
              ($urandom_range(0, 2) != 0),
              3'($urandom),
              ($urandom_range(0, 1) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/p_dec_3x8_buf.md
Name: p_dec_3x8_buf

Overview:
- Buffered 3-to-8 decoder: the expanding counterpart of the 8x3 priority encoder.
- Accepts a stream of 3-bit codes qualified by a valid bit, queues them in a small FIFO, and presents each one as a registered one-hot 8-bit line held until acknowledged.
- Sits on the consumer side of an encoder link, turning encoded requests back into per-line strobes for downstream logic.

Parameters:
- DEPTH, 4: FIFO entries behind the output register; power of two, ≥2. Total capacity is DEPTH+1 codes.
- LW, 3: width of the lvl output; must satisfy 2^LW > DEPTH+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset; sampled on the clk rising edge
- Q  in  3  encoded line index
- v  in  1  Q valid; a code is accepted on any edge with v=1 and rdy=1
- rdy  out  1  FIFO not full; registered, with no combinational path from ack
- D  out  8  one-hot decode of the current code; 8'h00 when D_v=0
- D_v  out  1  D holds a code
- ack  in  1  consumer accepts D; ignored when D_v=0
- lvl  out  LW  codes held (output register + FIFO), 0..DEPTH+1
- ovf  out  1  sticky: a code was offered (v=1) while rdy=0 and was dropped

Behaviour:
- Reset (rst_n=0 at an edge):
  - D=8'h00, D_v=0, rdy=1, lvl=0, ovf=0.
  - FIFO read/write pointers = 0.
  - Reset wins over every other input on that edge, including mid-transfer; buffered codes are discarded.
- Output stage FSM, two states:
  - EMPTY: D_v=0, D=0.
  - SHOW: D_v=1, D = 1<<code.
  - EMPTY -> SHOW when a code is available: FIFO head if non-empty, else bypass of an accepted Q.
  - SHOW -> SHOW with the next code when ack=1 and a code is available; back-to-back, no bubble cycle.
  - SHOW -> EMPTY when ack=1 and nothing is available.
- Bypass: if the FIFO is empty and the output stage is EMPTY (or being freed by ack), an accepted Q loads straight into D on that edge. Latency is 1 cycle from the accept edge to D_v=1. Otherwise Q is written to the FIFO tail.
- Ordering is strict FIFO; no priority or reordering.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full = (MSBs differ, LSBs equal); empty = (pointers equal).
- rdy = !full, computed from registered state only. When full, a same-cycle ack does not make room for that cycle's Q: the code is dropped and ovf sets. Next cycle rdy=1.
- lvl: +1 on accept, −1 on ack with D_v=1, unchanged when both occur. lvl never exceeds DEPTH+1 and never underflows.
- ovf: set on any edge with v=1 and rdy=0. Cleared only by reset.
- Q is don't-care when v=0. All 8 codes are legal; code 0 decodes to 8'h01, code 7 to 8'h80.
- D is always exactly one-hot or zero, and is zero iff D_v=0.

Test Plan:
- Reset then idle -> D=00, D_v=0, rdy=1, lvl=0, ovf=0. Assert rst_n=0 with D_v=1 and lvl=3 -> all outputs return to reset values at the next edge.
- Single code Q=5, v=1 for one cycle, ack=0 -> D=8'h20, D_v=1 one cycle later, lvl=1; held until ack=1, then D=00, D_v=0, lvl=0.
- Burst Q=0..7 with ack=0 and DEPTH=4 -> codes 0..4 accepted, lvl=5, rdy=0 after the 5th accept, codes 5..7 dropped, ovf=1. Then ack held high -> D sequence 01,02,04,08,10 on consecutive cycles, then D_v=0.
- Streaming with ack=1 continuously, Q=3,6,1 on consecutive cycles -> D=08,40,02 on consecutive cycles with 1-cycle latency; lvl stays ≤1; ovf=0.
- Full FIFO plus simultaneous ack and v=1 (Q=2) -> head advances, Q=2 is dropped, ovf=1, lvl decrements by 1; next cycle rdy=1.
- Pointer wrap: 3·DEPTH push/pop cycles with mixed codes -> output order matches input order, and no spurious full/empty flags at the wrap point.
